pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be:
  REG_ADDR_W, default 5, register-address width.
  LOAD_STALL_CYCLES, default 1, range 1..15, load-use stall length.
  FLUSH_CYCLES, default 1, range 1..15, branch flush length.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single clock, rising edge.
  resetN  in  1  reset, asynchronous, active-low.
  idExMemRead  in  1  ID/EX holds a load.
  idExRegWrite  in  1  ID/EX writes a register.
  idExRs, idExRt, idExRd  in  REG_ADDR_W  ID/EX source and destination fields.
  exMemRegWrite, memWbRegWrite  in  1  later-stage write enables.
  exMemRd, memWbRd  in  REG_ADDR_W  later-stage destinations.
  ifIdRs, ifIdRt  in  REG_ADDR_W  IF/ID source fields.
  ifIdUsesRt  in  1  IF/ID instruction reads rt.
  branchTaken  in  1  EX resolved a taken branch.
  memBusy  in  1  data memory not ready; freeze request.
  pcWrite, ifIdWrite  out  1  PC and IF/ID enables.
  bubbleInstruction  out  1  zero ID/EX controls.
  ifIdFlush  out  1  clear IF/ID.
  forwardA, forwardB  out  2  ALU operand select; 00 regfile, 10 EX/MEM, 01 MEM/WB.

Function
REQ-003 FSM states SHALL be RUN, LOAD_STALL and FLUSH, with a 4-bit down-counter cnt.
REQ-004 loadHaz SHALL be idExMemRead & idExRt!=0 & (idExRt==ifIdRs | (ifIdUsesRt & idExRt==ifIdRt)).
REQ-005 Register 0 SHALL never produce a hazard or a forward.
REQ-006 In RUN with no event: pcWrite=1, ifIdWrite=1, bubbleInstruction=0, ifIdFlush=0.
REQ-007 When branchTaken=1 in RUN, the block SHALL assert ifIdFlush=1 and bubbleInstruction=1 in the same cycle.
REQ-008 On that branchTaken cycle, if FLUSH_CYCLES>1 the FSM SHALL go to FLUSH with cnt=FLUSH_CYCLES-2.
REQ-009 branchTaken SHALL take priority over loadHaz in the same cycle; the load stall is discarded.
REQ-010 When loadHaz=1 in RUN without branchTaken, the block SHALL drive pcWrite=0, ifIdWrite=0, bubbleInstruction=1 combinationally in the same cycle.
REQ-011 On that loadHaz cycle, if LOAD_STALL_CYCLES>1 the FSM SHALL go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-2.
REQ-012 In LOAD_STALL, outputs SHALL equal those of REQ-010 regardless of idExMemRead; return to RUN after the cycle with cnt==0.
REQ-013 In FLUSH, outputs SHALL equal those of REQ-007; return to RUN after the cycle with cnt==0.
REQ-014 branchTaken SHALL be ignored while in FLUSH or LOAD_STALL.
REQ-015 Total stall length SHALL be exactly LOAD_STALL_CYCLES cycles, and total flush length exactly FLUSH_CYCLES cycles.
REQ-016 memBusy=1 SHALL override all states: pcWrite=0, ifIdWrite=0, bubbleInstruction=0, ifIdFlush=0; state and cnt held.
REQ-017 A new hazard or branch SHALL NOT be evaluated while memBusy=1.
REQ-018 The FSM, cnt and forward logic SHALL be the only state; all other outputs are combinational from state and inputs.

Reset
REQ-019 While resetN=0, all outputs SHALL be 0 and forwardA/forwardB SHALL be 00, independent of clk.
REQ-020 Reset SHALL set state=RUN and cnt=0; a stall or flush in progress SHALL be abandoned.
REQ-021 On the first edge after release the block SHALL evaluate inputs as in RUN.

Configuration
REQ-022 The macro HAZARD_FORWARD_EN SHALL select forwarding.
REQ-023 With HAZARD_FORWARD_EN defined, forwardA SHALL be:
  10 if exMemRegWrite & exMemRd!=0 & exMemRd==idExRs;
  else 01 if memWbRegWrite & memWbRd!=0 & memWbRd==idExRs;
  else 00.
  forwardB SHALL follow the same rule using idExRt.
REQ-024 With HAZARD_FORWARD_EN undefined, forwardA and forwardB SHALL be constant 00.
REQ-025 With HAZARD_FORWARD_EN undefined, loadHaz SHALL also include a RAW match of IF/ID sources against idExRd (idExRegWrite) and exMemRd (exMemRegWrite); each such match stalls one cycle per detection.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding and the forward-select constants FWD_REG=00, FWD_EXMEM=10, FWD_MEMWB=01.
REQ-027 One sub-module, hazard_fwd_sel, SHALL implement the REQ-023 priority compare and be instantiated twice.

Verification
REQ-028 Directed scenarios:
  - Reset mid-stall: LOAD_STALL_CYCLES=3, loadHaz, resetN=0 on 2nd stall cycle -> outputs 0 immediately; after release, pcWrite=1.
  - Load-use: idExMemRead=1, idExRt=5, ifIdRs=5, LOAD_STALL_CYCLES=2 -> pcWrite=0 and bubbleInstruction=1 for exactly 2 cycles, then 1/0.
  - Reg-0 and branch priority: idExRt=0=ifIdRs -> no stall; loadHaz with branchTaken same cycle, FLUSH_CYCLES=2 -> ifIdFlush=1 for 2 cycles, no stall.
  - memBusy mid-flush: memBusy=1 for 3 cycles on 1st FLUSH cycle -> all outputs 0 for 3 cycles, flush then completes its remaining cycle.
  - Forward priority (macro on): exMemRd=memWbRd=7=idExRs, both writes=1 -> forwardA=10; exMemRegWrite=0 -> 01.
  - Macro off: idExRegWrite=1, idExRd=4=ifIdRt, ifIdUsesRt=1 -> 1-cycle stall, forwardA/forwardB stay 00.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl_pkg : shared FSM encoding and forward selects   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipeline_hazard_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_fwd_sel : one ALU operand forward select, EX/MEM over MEM/WB  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_fwd_sel
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_mem_we,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  mem_wb_we,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [REG_ADDR_W-1:0] src,
  output logic [1:0]            sel
);

  always_comb begin
    sel = FWD_REG;
    if (ex_mem_we && (ex_mem_rd != '0) && (ex_mem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (mem_wb_we && (mem_wb_rd != '0) && (mem_wb_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl : load-use stall, branch flush, memory freeze   |
// | and optional forwarding (macro HAZARD_FORWARD_EN).                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  idExMemRead,
  input  logic                  idExRegWrite,
  input  logic [REG_ADDR_W-1:0] idExRs,
  input  logic [REG_ADDR_W-1:0] idExRt,
  input  logic [REG_ADDR_W-1:0] idExRd,
  input  logic                  exMemRegWrite,
  input  logic                  memWbRegWrite,
  input  logic [REG_ADDR_W-1:0] exMemRd,
  input  logic [REG_ADDR_W-1:0] memWbRd,
  input  logic [REG_ADDR_W-1:0] ifIdRs,
  input  logic [REG_ADDR_W-1:0] ifIdRt,
  input  logic                  ifIdUsesRt,
  input  logic                  branchTaken,
  input  logic                  memBusy,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  bubbleInstruction,
  output logic                  ifIdFlush,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pc_we, ifid_we, bubble, flush;
  logic             load_haz, raw_haz;
  logic [1:0]       fwd_a, fwd_b;

  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] dst,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rt,
                                   input logic                  uses_rt);
    return (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

  assign load_haz = idExMemRead && src_hit(idExRt, ifIdRs, ifIdRt, ifIdUsesRt);

`ifdef HAZARD_FORWARD_EN
  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_mem_we (exMemRegWrite),
    .ex_mem_rd (exMemRd),
    .mem_wb_we (memWbRegWrite),
    .mem_wb_rd (memWbRd),
    .src       (idExRs),
    .sel       (fwd_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_mem_we (exMemRegWrite),
    .ex_mem_rd (exMemRd),
    .mem_wb_we (memWbRegWrite),
    .mem_wb_rd (memWbRd),
    .src       (idExRt),
    .sel       (fwd_b)
  );

  assign raw_haz = 1'b0;
  logic unused_nofwd;
  assign unused_nofwd = &{1'b0, idExRegWrite, idExRd};
`else
  // Without forwarding, any in-flight producer of an IF/ID source must be waited out.
  assign raw_haz = (idExRegWrite  && src_hit(idExRd,  ifIdRs, ifIdRt, ifIdUsesRt)) ||
                   (exMemRegWrite && src_hit(exMemRd, ifIdRs, ifIdRt, ifIdUsesRt));
  assign fwd_a   = FWD_REG;
  assign fwd_b   = FWD_REG;
  logic unused_fwd;
  assign unused_fwd = &{1'b0, idExRs, memWbRegWrite, memWbRd};
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    bubble    = 1'b0;
    flush     = 1'b0;
    if (memBusy) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (branchTaken) begin
            bubble = 1'b1;
            flush  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = ST_FLUSH;
              cnt_nxt   = CNT_W'(FLUSH_CYCLES - 2);
            end
          end else if (load_haz || raw_haz) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
            // A RAW match without a load clears itself once the producer advances.
            if (load_haz && (LOAD_STALL_CYCLES > 1)) begin
              state_nxt = ST_LOAD_STALL;
              cnt_nxt   = CNT_W'(LOAD_STALL_CYCLES - 2);
            end
          end
        end
        ST_LOAD_STALL: begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          bubble  = 1'b1;
          if (cnt == '0) state_nxt = ST_RUN;
          else           cnt_nxt   = cnt - 4'd1;
        end
        ST_FLUSH: begin
          bubble = 1'b1;
          flush  = 1'b1;
          if (cnt == '0) state_nxt = ST_RUN;
          else           cnt_nxt   = cnt - 4'd1;
        end
        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign pcWrite           = resetN & pc_we;
  assign ifIdWrite         = resetN & ifid_we;
  assign bubbleInstruction = resetN & bubble;
  assign ifIdFlush         = resetN & flush;
  assign forwardA          = {2{resetN}} & fwd_a;
  assign forwardB          = {2{resetN}} & fwd_b;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl : directed checks on two parameterisations   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  localparam int W = 5;
  localparam logic [3:0] RUN_O = 4'b1100;
  localparam logic [3:0] STL_O = 4'b0010;
  localparam logic [3:0] FLS_O = 4'b1111;
  localparam logic [3:0] ZRO_O = 4'b0000;

  logic         clk = 1'b0;
  logic         resetN;
  logic         idExMemRead, idExRegWrite, exMemRegWrite, memWbRegWrite;
  logic [W-1:0] idExRs, idExRt, idExRd, exMemRd, memWbRd, ifIdRs, ifIdRt;
  logic         ifIdUsesRt, branchTaken, memBusy;

  logic       pc_a, ifid_a, bub_a, fl_a, pc_b, ifid_b, bub_b, fl_b;
  logic [1:0] fa_a, fb_a, fa_b, fb_b;
  wire  [3:0] out_a = {pc_a, ifid_a, bub_a, fl_a};
  wire  [3:0] out_b = {pc_b, ifid_b, bub_b, fl_b};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut_a: 3-cycle load stall; dut_b: 2-cycle load stall; both 2-cycle flush
  pipeline_hazard_ctrl #(.REG_ADDR_W(W), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .resetN(resetN), .idExMemRead(idExMemRead), .idExRegWrite(idExRegWrite),
    .idExRs(idExRs), .idExRt(idExRt), .idExRd(idExRd), .exMemRegWrite(exMemRegWrite),
    .memWbRegWrite(memWbRegWrite), .exMemRd(exMemRd), .memWbRd(memWbRd),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRt(ifIdUsesRt), .branchTaken(branchTaken),
    .memBusy(memBusy), .pcWrite(pc_a), .ifIdWrite(ifid_a), .bubbleInstruction(bub_a),
    .ifIdFlush(fl_a), .forwardA(fa_a), .forwardB(fb_a)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(W), .LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2)) dut_b (
    .clk(clk), .resetN(resetN), .idExMemRead(idExMemRead), .idExRegWrite(idExRegWrite),
    .idExRs(idExRs), .idExRt(idExRt), .idExRd(idExRd), .exMemRegWrite(exMemRegWrite),
    .memWbRegWrite(memWbRegWrite), .exMemRd(exMemRd), .memWbRd(memWbRd),
    .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRt(ifIdUsesRt), .branchTaken(branchTaken),
    .memBusy(memBusy), .pcWrite(pc_b), .ifIdWrite(ifid_b), .bubbleInstruction(bub_b),
    .ifIdFlush(fl_b), .forwardA(fa_b), .forwardB(fb_b)
  );

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    idExMemRead = 0; idExRegWrite = 0; exMemRegWrite = 0; memWbRegWrite = 0;
    idExRs = 0; idExRt = 0; idExRd = 0; exMemRd = 0; memWbRd = 0;
    ifIdRs = 0; ifIdRt = 0; ifIdUsesRt = 0; branchTaken = 0; memBusy = 0;
  endtask

  task automatic load_use();
    idExMemRead = 1; idExRt = 5; ifIdRs = 5;
  endtask

  // inputs change 2 time units after the rising edge, checks follow 1 unit later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    resetN = 0;
    idle_inputs();
    #2;
    check("rst_out_a", 8'(out_a), 8'(ZRO_O));
    check("rst_out_b", 8'(out_b), 8'(ZRO_O));
    check("rst_fwd", 8'({fa_a, fb_a, fa_b, fb_b}), 8'h00);
    tick(); tick();
    resetN = 1;
    #1 check("idle_a", 8'(out_a), 8'(RUN_O));

    // load-use: 3 stall cycles on dut_a, 2 on dut_b
    tick(); load_use();
    #1 check("lu_c1_b", 8'(out_b), 8'(STL_O));
    check("lu_c1_a", 8'(out_a), 8'(STL_O));
    tick(); idle_inputs();
    #1 check("lu_c2_b", 8'(out_b), 8'(STL_O));
    check("lu_c2_a", 8'(out_a), 8'(STL_O));
    tick();
    #1 check("lu_c3_b", 8'(out_b), 8'(RUN_O));
    check("lu_c3_a", 8'(out_a), 8'(STL_O));
    tick();
    #1 check("lu_c4_a", 8'(out_a), 8'(RUN_O));

    // register 0 never hazards
    tick(); idExMemRead = 1; idExRt = 0; ifIdRs = 0;
    #1 check("reg0_nostall", 8'(out_a), 8'(RUN_O));

    // branch beats a simultaneous load-use hazard
    tick(); load_use(); branchTaken = 1;
    #1 check("br_pri_c1", 8'(out_a), 8'(FLS_O));
    tick(); idle_inputs(); load_use(); branchTaken = 1;
    #1 check("br_pri_c2", 8'(out_a), 8'(FLS_O));
    tick(); idle_inputs();
    #1 check("br_pri_done_a", 8'(out_a), 8'(RUN_O));
    check("br_pri_done_b", 8'(out_b), 8'(RUN_O));

    // memBusy freezes a flush in progress
    tick(); branchTaken = 1;
    #1 check("mb_br", 8'(out_a), 8'(FLS_O));
    for (int i = 0; i < 3; i++) begin
      tick(); idle_inputs(); memBusy = 1; load_use(); branchTaken = 1;
      #1 check($sformatf("mb_busy%0d", i), 8'(out_a), 8'(ZRO_O));
    end
    tick(); idle_inputs();
    #1 check("mb_flush_rest", 8'(out_a), 8'(FLS_O));
    tick();
    #1 check("mb_after", 8'(out_a), 8'(RUN_O));

    // memBusy in RUN hides a hazard
    tick(); memBusy = 1; load_use();
    #1 check("mb_run", 8'(out_b), 8'(ZRO_O));
    tick(); idle_inputs();
    #1 check("mb_run_after", 8'(out_b), 8'(RUN_O));

    // reset during the second cycle of a 3-cycle stall
    tick(); load_use();
    #1 check("rs_c1", 8'(out_a), 8'(STL_O));
    tick(); idle_inputs();
    #1 check("rs_c2", 8'(out_a), 8'(STL_O));
    resetN = 0;
    #1 check("rs_async_a", 8'(out_a), 8'(ZRO_O));
    check("rs_async_b", 8'(out_b), 8'(ZRO_O));
    tick();
    #1 check("rs_held", 8'(out_a), 8'(ZRO_O));
    resetN = 1;
    #1 check("rs_release", 8'(out_a), 8'(RUN_O));
    tick();
    #1 check("rs_after_edge", 8'(out_a), 8'(RUN_O));

    // RAW match against idExRd: one-cycle stall only without forwarding
    tick(); idExRegWrite = 1; idExRd = 4; ifIdRt = 4; ifIdUsesRt = 1;
`ifdef HAZARD_FORWARD_EN
    #1 check("raw_c1", 8'(out_b), 8'(RUN_O));
`else
    #1 check("raw_c1", 8'(out_b), 8'(STL_O));
`endif
    check("raw_fwd", 8'({fa_b, fb_b}), 8'h00);
    tick(); idle_inputs();
    #1 check("raw_c2", 8'(out_b), 8'(RUN_O));

    // forward priority
    tick(); idExRs = 7; idExRt = 7; exMemRd = 7; memWbRd = 7;
    exMemRegWrite = 1; memWbRegWrite = 1;
`ifdef HAZARD_FORWARD_EN
    #1 check("fwdA_exmem", 8'(fa_a), 8'h2);
    check("fwdB_exmem", 8'(fb_a), 8'h2);
`else
    #1 check("fwdA_off", 8'(fa_a), 8'h0);
    check("fwdB_off", 8'(fb_a), 8'h0);
`endif
    check("fwd_nostall", 8'(out_a), 8'(RUN_O));
    tick(); exMemRegWrite = 0;
`ifdef HAZARD_FORWARD_EN
    #1 check("fwdA_memwb", 8'(fa_a), 8'h1);
`else
    #1 check("fwdA_off2", 8'(fa_a), 8'h0);
`endif
    tick(); exMemRegWrite = 1; exMemRd = 0;
`ifdef HAZARD_FORWARD_EN
    #1 check("fwdA_exmem_r0", 8'(fa_a), 8'h1);
`else
    #1 check("fwdA_off3", 8'(fa_a), 8'h0);
`endif
    tick(); idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
